pcie_hcmd_nlb_sched: RTL and testbench

PCIE_HCMD_NLB_SCHED -- requirements
Module: pcie_hcmd_nlb_sched

---
 rtl/pcie_hcmd_nlb_sched_if.sv | 48 ++++
 rtl/pcie_hcmd_nlb_sched.sv | 135 +++++++++++++
 tb/tb_pcie_hcmd_nlb_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pcie_hcmd_nlb_sched_if.sv
// Requester, NLB-table and status signals of the NLB decrement scheduler.
// The scheduler binds to the slave modport; the environment drives through master.
interface pcie_hcmd_nlb_sched_if #(
  parameter int P_SLOT_TAG_WIDTH = 10,
  parameter int P_DATA_WIDTH     = 19
);
  logic                        req0_valid;
  logic [P_SLOT_TAG_WIDTH-1:0] req0_slot_tag;
  logic [P_DATA_WIDTH-1:0]     req0_dec;
  logic                        req0_ack;
  logic                        req1_valid;
  logic [P_SLOT_TAG_WIDTH-1:0] req1_slot_tag;
  logic [P_DATA_WIDTH-1:0]     req1_dec;
  logic                        req1_ack;
  logic [P_SLOT_TAG_WIDTH-1:0] nlb_rd_addr;
  logic [P_DATA_WIDTH-1:0]     nlb_rd_data;
  logic                        nlb_wr_en;
  logic [P_SLOT_TAG_WIDTH-1:0] nlb_wr_addr;
  logic [P_DATA_WIDTH-1:0]     nlb_wr_data;
  logic                        nlb_wr_rdy_n;
  logic                        cmpl_valid;
  logic [P_SLOT_TAG_WIDTH-1:0] cmpl_slot_tag;
  logic                        underflow_err;

  modport slave (
    input  req0_valid, req0_slot_tag, req0_dec,
    output req0_ack,
    input  req1_valid, req1_slot_tag, req1_dec,
    output req1_ack,
    output nlb_rd_addr,
    input  nlb_rd_data,
    output nlb_wr_en, nlb_wr_addr, nlb_wr_data,
    input  nlb_wr_rdy_n,
    output cmpl_valid, cmpl_slot_tag, underflow_err
  );

  modport master (
    output req0_valid, req0_slot_tag, req0_dec,
    input  req0_ack,
    output req1_valid, req1_slot_tag, req1_dec,
    input  req1_ack,
    input  nlb_rd_addr,
    output nlb_rd_data,
    input  nlb_wr_en, nlb_wr_addr, nlb_wr_data,
    output nlb_wr_rdy_n,
    input  cmpl_valid, cmpl_slot_tag, underflow_err
  );
endinterface

// File: rtl/pcie_hcmd_nlb_sched.sv
// Two-requester round-robin scheduler performing one read-modify-write
// decrement of the NLB table at a time, with zero-reach and underflow status.
module pcie_hcmd_nlb_sched #(
  parameter int P_SLOT_TAG_WIDTH = 10,
  parameter int P_DATA_WIDTH     = 19
) (
  input logic                   clk,
  input logic                   rst,
  pcie_hcmd_nlb_sched_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_WAIT} state_t;

  state_t                      state_q, state_d;
  logic                        gnt_q, gnt_d;
  logic                        pref1_q, pref1_d;
  logic [P_SLOT_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [P_DATA_WIDTH-1:0]     dec_q, dec_d;
  logic [P_DATA_WIDTH-1:0]     res_q, res_d;
  logic                        uf_q, uf_d;
  logic                        wr_en_q, wr_en_d;
  logic                        ack0_q, ack0_d;
  logic                        ack1_q, ack1_d;
  logic                        cmpl_q, cmpl_d;
  logic                        uf_err_q, uf_err_d;
  logic [P_SLOT_TAG_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [P_DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [P_SLOT_TAG_WIDTH-1:0] cmpl_tag_q, cmpl_tag_d;
  logic                        pick1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    pref1_d    = pref1_q;
    tag_d      = tag_q;
    dec_d      = dec_q;
    res_d      = res_q;
    uf_d       = uf_q;
    wr_en_d    = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    cmpl_d     = 1'b0;
    uf_err_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cmpl_tag_d = cmpl_tag_q;
    pick1      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // pref1_q only matters on a tie; a lone requester always wins
          pick1   = bus.req1_valid && (!bus.req0_valid || pref1_q);
          gnt_d   = pick1;
          pref1_d = !pick1;
          tag_d   = pick1 ? bus.req1_slot_tag : bus.req0_slot_tag;
          dec_d   = pick1 ? bus.req1_dec : bus.req0_dec;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_CALC;
      S_CALC: begin
        if (dec_q > bus.nlb_rd_data) begin
          res_d = '0;
          uf_d  = 1'b1;
        end else begin
          res_d = bus.nlb_rd_data - dec_q;
          uf_d  = 1'b0;
        end
        state_d = S_WR;
      end
      S_WR: begin
        if (!bus.nlb_wr_rdy_n) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tag_q;
          wr_data_d = res_q;
          ack0_d    = !gnt_q;
          ack1_d    = gnt_q;
          uf_err_d  = uf_q;
          if (res_q == '0) begin
            cmpl_d     = 1'b1;
            cmpl_tag_d = tag_q;
          end
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (!bus.nlb_wr_rdy_n) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      pref1_q    <= 1'b0;
      tag_q      <= '0;
      dec_q      <= '0;
      res_q      <= '0;
      uf_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      cmpl_q     <= 1'b0;
      uf_err_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cmpl_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pref1_q    <= pref1_d;
      tag_q      <= tag_d;
      dec_q      <= dec_d;
      res_q      <= res_d;
      uf_q       <= uf_d;
      wr_en_q    <= wr_en_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      cmpl_q     <= cmpl_d;
      uf_err_q   <= uf_err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cmpl_tag_q <= cmpl_tag_d;
    end
  end

  assign bus.nlb_rd_addr   = tag_q;
  assign bus.nlb_wr_en     = wr_en_q;
  assign bus.nlb_wr_addr   = wr_addr_q;
  assign bus.nlb_wr_data   = wr_data_q;
  assign bus.req0_ack      = ack0_q;
  assign bus.req1_ack      = ack1_q;
  assign bus.cmpl_valid    = cmpl_q;
  assign bus.cmpl_slot_tag = cmpl_tag_q;
  assign bus.underflow_err = uf_err_q;
endmodule

// File: tb/tb_pcie_hcmd_nlb_sched.sv
// Directed vector bench for pcie_hcmd_nlb_sched with a behavioural NLB table.
module tb_pcie_hcmd_nlb_sched;
  localparam int TW = 10;
  localparam int DW = 19;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcie_hcmd_nlb_sched_if #(.P_SLOT_TAG_WIDTH(TW), .P_DATA_WIDTH(DW)) bus ();
  pcie_hcmd_nlb_sched #(.P_SLOT_TAG_WIDTH(TW), .P_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Table model: registered read, write port, plus a preload path.
  logic [DW-1:0] mem [1024];
  logic          pre_en;
  logic [TW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    bus.nlb_rd_data <= mem[bus.nlb_rd_addr];
    if (bus.nlb_wr_en) mem[bus.nlb_wr_addr] <= bus.nlb_wr_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [TW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic issue(input bit who, input logic [TW-1:0] tag, input logic [DW-1:0] dec);
    if (who) begin
      bus.req1_slot_tag = tag; bus.req1_dec = dec; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_slot_tag = tag; bus.req0_dec = dec; bus.req0_valid = 1'b1;
    end
  endtask

  // Snapshot of the output bundle on the ack cycle.
  logic          o_we, o_a0, o_a1, o_cmpl, o_uf;
  logic [TW-1:0] o_addr, o_ctag;
  logic [DW-1:0] o_data;

  task automatic wait_ack(output int lat);
    lat = -1;
    {o_we, o_a0, o_a1, o_cmpl, o_uf} = '0;
    o_addr = '0; o_ctag = '0; o_data = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.nlb_wr_en || bus.req0_ack || bus.req1_ack) begin
        lat    = c;
        o_we   = bus.nlb_wr_en;   o_a0   = bus.req0_ack; o_a1 = bus.req1_ack;
        o_cmpl = bus.cmpl_valid;  o_uf   = bus.underflow_err;
        o_addr = bus.nlb_wr_addr; o_data = bus.nlb_wr_data;
        o_ctag = bus.cmpl_slot_tag;
        break;
      end
    end
  endtask

  typedef struct {
    bit            who;
    logic [TW-1:0] tag;
    logic [DW-1:0] init;
    logic [DW-1:0] dec;
    logic [DW-1:0] exp;
    bit            cmpl;
    bit            uf;
  } vec_t;

  vec_t vecs [7];
  int   lat;
  logic any_pulse;
  logic [3:0] who_seq;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 10'd5,    19'd8,       19'd3,       19'd5,       1'b0, 1'b0};
    vecs[1] = '{1, 10'd7,    19'd4,       19'd4,       19'd0,       1'b1, 1'b0};
    vecs[2] = '{0, 10'd2,    19'd1,       19'd6,       19'd0,       1'b1, 1'b1};
    vecs[3] = '{1, 10'd12,   19'd100,     19'd0,       19'd100,     1'b0, 1'b0};
    vecs[4] = '{0, 10'd1023, 19'h7FFFF,   19'd1,       19'h7FFFE,   1'b0, 1'b0};
    vecs[5] = '{1, 10'd0,    19'd0,       19'd1,       19'd0,       1'b1, 1'b1};
    vecs[6] = '{1, 10'd33,   19'h7FFFF,   19'h7FFFF,   19'd0,       1'b1, 1'b0};

    rst = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req0_valid = 1'b0; bus.req0_slot_tag = '0; bus.req0_dec = '0;
    bus.req1_valid = 1'b0; bus.req1_slot_tag = '0; bus.req1_dec = '0;
    bus.nlb_wr_rdy_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pulses", {bus.nlb_wr_en, bus.req0_ack, bus.req1_ack, bus.cmpl_valid, bus.underflow_err}, 0);
    chk("reset_rd_addr", bus.nlb_rd_addr, 0);
    chk("reset_wr_addr", bus.nlb_wr_addr, 0);
    chk("reset_wr_data", bus.nlb_wr_data, 0);
    chk("reset_cmpl_tag", bus.cmpl_slot_tag, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      preload(vecs[i].tag, vecs[i].init);
      issue(vecs[i].who, vecs[i].tag, vecs[i].dec);
      wait_ack(lat);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_wr_en", i), o_we, 1);
      chk($sformatf("v%0d_acks", i), {o_a1, o_a0}, vecs[i].who ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_wr_addr", i), o_addr, vecs[i].tag);
      chk($sformatf("v%0d_wr_data", i), o_data, vecs[i].exp);
      chk($sformatf("v%0d_cmpl", i), o_cmpl, vecs[i].cmpl);
      if (vecs[i].cmpl) chk($sformatf("v%0d_cmpl_tag", i), o_ctag, vecs[i].tag);
      chk($sformatf("v%0d_underflow", i), o_uf, vecs[i].uf);
      @(negedge clk);
      chk($sformatf("v%0d_one_pulse", i),
          {bus.nlb_wr_en, bus.req0_ack, bus.req1_ack, bus.cmpl_valid, bus.underflow_err}, 0);
      chk($sformatf("v%0d_table", i), mem[vecs[i].tag], vecs[i].exp);
      @(negedge clk);
    end

    // Contention: fresh reset so req0 takes the first tie.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    preload(10'd9, 19'd10);
    issue(0, 10'd9, 19'd1);
    issue(1, 10'd9, 19'd1);
    for (int k = 0; k < 4; k++) begin
      wait_ack(lat);
      if (k == 3) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end
      who_seq[k] = o_a1;
      chk($sformatf("rr%0d_spacing", k), lat, (k == 0) ? 3 : 4);
      chk($sformatf("rr%0d_one_ack", k), o_a0 ^ o_a1, 1);
      chk($sformatf("rr%0d_wr_data", k), o_data, 19'd9 - 19'(k));
    end
    chk("rr_grant_order", who_seq, 4'b1010);
    repeat (2) @(negedge clk);
    chk("rr_table9", mem[9], 6);

    // Backpressure: write port busy while the update sits in WR.
    bus.nlb_wr_rdy_n = 1'b1;
    preload(10'd3, 19'd20);
    issue(0, 10'd3, 19'd5);
    any_pulse = 1'b0;
    repeat (9) begin
      @(negedge clk);
      any_pulse = any_pulse | bus.nlb_wr_en | bus.req0_ack | bus.req1_ack;
    end
    chk("bp_no_write_while_busy", any_pulse, 0);
    bus.nlb_wr_rdy_n = 1'b0;
    wait_ack(lat);
    bus.req0_valid = 1'b0;
    chk("bp_release_latency", lat, 0);
    chk("bp_wr_data", o_data, 15);
    chk("bp_ack0", {o_a1, o_a0, o_we}, 3'b011);
    @(negedge clk);
    chk("bp_one_write", bus.nlb_wr_en, 0);
    @(negedge clk);
    chk("bp_table3", mem[3], 15);

    // Reset while the update is in CALC; the held request is served again.
    preload(10'd4, 19'd30);
    issue(1, 10'd4, 19'd10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rc_pulses_in_reset", {bus.nlb_wr_en, bus.req0_ack, bus.req1_ack, bus.cmpl_valid, bus.underflow_err}, 0);
    rst = 1'b0;
    wait_ack(lat);
    bus.req1_valid = 1'b0;
    chk("rc_latency_after_reset", lat, 3);
    chk("rc_ack1", {o_a1, o_a0}, 2'b10);
    chk("rc_wr_data", o_data, 20);
    repeat (2) @(negedge clk);
    chk("rc_table4", mem[4], 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
